// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_controller: PC owner, imem sequencer and fetch queue    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module instruction_fetch_controller #(
  parameter int          SIZE_EXP2    = 10,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2,
  parameter logic [31:0] HALT_WORD    = 32'h0000_000C
) (
  input  logic                 system_clock,
  input  logic                 reset,
  output logic [SIZE_EXP2-1:0] imem_address,
  input  logic [31:0]          imem_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 id_ready,
  output logic                 if_valid,
  output logic [31:0]          if_instruction,
  output logic [31:0]          if_pc,
  output logic                 halted,
  output logic [31:0]          fetch_count
);

  localparam int              PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int              CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  logic [31:0] instr_q [QUEUE_DEPTH];
  logic [31:0] qpc_q   [QUEUE_DEPTH];

  logic w_pop;
  logic w_fetch;

  assign if_valid       = (count_q != '0);
  assign if_instruction = if_valid ? instr_q[head_q] : 32'h0;
  assign if_pc          = if_valid ? qpc_q[head_q] : 32'h0;
  assign halted         = (state_q == ST_HALTED);
  assign fetch_count    = fetch_count_q;
  assign imem_address   = pc_q[SIZE_EXP2+1:2];

  // A redirect kills both the pop and the fetch of its cycle.
  assign w_pop   = if_valid & id_ready & ~redirect_valid;
  assign w_fetch = (state_q == ST_FETCH) & ~redirect_valid &
                   ((count_q < CNT_FULL) | (if_valid & id_ready));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      state_d = ST_FETCH;
    end else begin
      if (w_pop) begin
        head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
      end
      if (w_fetch) begin
        tail_d        = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
        fetch_count_d = fetch_count_q + 32'd1;
        // The halt word is still handed to ID; only the PC stops advancing.
        if (imem_data == HALT_WORD) begin
          state_d = ST_HALTED;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (w_fetch && !w_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (w_pop && !w_fetch) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_VECTOR;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge system_clock) begin
    if (w_fetch) begin
      instr_q[tail_q] <= imem_data;
      qpc_q[tail_q]   <= pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch_controller: directed self-checking bench             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch_controller;

  localparam int          SIZE_EXP2 = 10;
  localparam logic [31:0] HALT_WORD = 32'h0000_000C;

  logic                 system_clock = 1'b0;
  logic                 reset;
  logic [SIZE_EXP2-1:0] imem_address;
  logic [31:0]          imem_data;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 id_ready;
  logic                 if_valid;
  logic [31:0]          if_instruction;
  logic [31:0]          if_pc;
  logic                 halted;
  logic [31:0]          fetch_count;

  logic [31:0] mem [1 << SIZE_EXP2];
  int checks = 0;
  int errors = 0;

  assign imem_data = mem[imem_address];

  always #5 system_clock = ~system_clock;

  instruction_fetch_controller #(
    .SIZE_EXP2   (SIZE_EXP2),
    .RESET_VECTOR(32'h0000_0000),
    .QUEUE_DEPTH (2),
    .HALT_WORD   (HALT_WORD)
  ) dut (
    .system_clock  (system_clock),
    .reset         (reset),
    .imem_address  (imem_address),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_instruction(if_instruction),
    .if_pc         (if_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic load_mem();
    for (int i = 0; i < (1 << SIZE_EXP2); i++) mem[i] = 32'hA000_0000 + 32'(i);
  endtask

  // Holds reset across an edge and releases it on a falling edge.
  task automatic apply_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    @(negedge system_clock);
    @(negedge system_clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    load_mem();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    @(negedge system_clock);
    checks += 5;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", if_valid); end
    if (if_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %0h want 0", if_instruction); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h want 0", if_pc); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h want 0", halted); end
    if (imem_address !== 10'h0 || fetch_count !== 32'h0) begin
      errors++; $display("FAIL reset_addr_cnt got %0h/%0h want 0/0", imem_address, fetch_count);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [4];
    exp_i = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    load_mem();
    apply_reset();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge system_clock);
      checks++;
      if (if_valid !== 1'b1 || if_instruction !== exp_i[k] || if_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_%0d got v=%0h i=%0h pc=%0h want v=1 i=%0h pc=%0h",
                 k, if_valid, if_instruction, if_pc, exp_i[k], 4 * k);
      end
    end
    checks++;
    if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_backpressure();
    load_mem();
    apply_reset();
    repeat (5) @(negedge system_clock);
    checks += 2;
    if (imem_address !== 10'd2 || fetch_count !== 32'd2) begin
      errors++; $display("FAIL bp_hold got addr=%0h cnt=%0d want addr=2 cnt=2", imem_address, fetch_count);
    end
    if (if_instruction !== 32'hA000_0000 || if_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head got i=%0h pc=%0h want A0000000/0", if_instruction, if_pc);
    end
    id_ready = 1'b1;
    @(negedge system_clock);
    checks++;
    if (if_instruction !== 32'hA000_0001 || if_pc !== 32'h4) begin
      errors++; $display("FAIL bp_second got i=%0h pc=%0h want A0000001/4", if_instruction, if_pc);
    end
    @(negedge system_clock);
    checks++;
    if (if_instruction !== 32'hA000_0002 || if_pc !== 32'h8 || fetch_count !== 32'd4) begin
      errors++; $display("FAIL bp_third got i=%0h pc=%0h cnt=%0d want A0000002/8/4", if_instruction, if_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    load_mem();
    mem[16] = 32'h1616_1616;
    apply_reset();
    repeat (3) @(negedge system_clock);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge system_clock);
    checks++;
    if (if_valid !== 1'b0 || fetch_count !== 32'd2 || imem_address !== 10'd16) begin
      errors++; $display("FAIL redir_flush got v=%0h cnt=%0d addr=%0h want 0/2/10", if_valid, fetch_count, imem_address);
    end
    redirect_valid = 1'b0;
    @(negedge system_clock);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instruction !== 32'h1616_1616) begin
      errors++; $display("FAIL redir_target got v=%0h pc=%0h i=%0h want 1/40/16161616", if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_halt();
    load_mem();
    mem[2] = HALT_WORD;
    mem[8] = 32'h8888_8888;
    apply_reset();
    id_ready = 1'b1;
    repeat (3) @(negedge system_clock);
    checks++;
    if (if_instruction !== HALT_WORD || if_pc !== 32'h8 || halted !== 1'b1 || fetch_count !== 32'd3) begin
      errors++; $display("FAIL halt_enter got i=%0h pc=%0h h=%0h cnt=%0d want C/8/1/3", if_instruction, if_pc, halted, fetch_count);
    end
    repeat (2) @(negedge system_clock);
    checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1 || imem_address !== 10'd2 || fetch_count !== 32'd3) begin
      errors++; $display("FAIL halt_hold got v=%0h h=%0h addr=%0h cnt=%0d want 0/1/2/3", if_valid, halted, imem_address, fetch_count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge system_clock);
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || imem_address !== 10'd8) begin
      errors++; $display("FAIL halt_exit got h=%0h addr=%0h want 0/8", halted, imem_address);
    end
    @(negedge system_clock);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instruction !== 32'h8888_8888) begin
      errors++; $display("FAIL halt_resume got v=%0h pc=%0h i=%0h want 1/20/88888888", if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_async_reset();
    load_mem();
    apply_reset();
    id_ready = 1'b1;
    repeat (3) @(negedge system_clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_address !== 10'd0 || fetch_count !== 32'd0) begin
      errors++; $display("FAIL async_rst got v=%0h addr=%0h cnt=%0d want 0/0/0", if_valid, imem_address, fetch_count);
    end
    @(negedge system_clock);
    reset = 1'b0;
    @(negedge system_clock);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'hA000_0000) begin
      errors++; $display("FAIL async_restart got v=%0h pc=%0h i=%0h want 1/0/A0000000", if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_wrap();
    load_mem();
    mem[10'h3FF] = 32'h3FF0_3FF0;
    mem[0]       = 32'h0BAD_F00D;
    apply_reset();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFE;
    @(negedge system_clock);
    redirect_valid = 1'b0;
    checks++;
    if (imem_address !== 10'h3FF || if_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_align got addr=%0h v=%0h want 3FF/0", imem_address, if_valid);
    end
    @(negedge system_clock);
    checks++;
    if (if_pc !== 32'hFFC || if_instruction !== 32'h3FF0_3FF0 || imem_address !== 10'h0) begin
      errors++; $display("FAIL wrap_last got pc=%0h i=%0h addr=%0h want FFC/3FF03FF0/0", if_pc, if_instruction, imem_address);
    end
    @(negedge system_clock);
    checks++;
    if (if_pc !== 32'h1000 || if_instruction !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL wrap_alias got pc=%0h i=%0h want 1000/0BADF00D", if_pc, if_instruction);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
